// File: rtl/multi_cycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes, ALU operation classes
// and the per-state output decode.
package multi_cycle_control_pkg;

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StMemAdr  = 4'd3,
    StMemRd   = 4'd4,
    StMemWb   = 4'd5,
    StMemWr   = 4'd6,
    StRExec   = 4'd7,
    StRWb     = 4'd8,
    StBranch  = 4'd9,
    StJump    = 4'd10,
    StIExec   = 4'd11,
    StIWb     = 4'd12,
    StIllegal = 4'd13
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpSlti  = 6'b001010;

  localparam logic [3:0] AluOpAdd  = 4'd0;
  localparam logic [3:0] AluOpSub  = 4'd1;
  localparam logic [3:0] AluOpFunc = 4'd2;
  localparam logic [3:0] AluOpAnd  = 4'd3;
  localparam logic [3:0] AluOpOr   = 4'd4;
  localparam logic [3:0] AluOpSlt  = 4'd5;

  // pc_write/ir_write are enables only; FETCH and BRANCH qualify them with MemReady/Zero.
  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [3:0] alu_op;
    logic       sign_extend;
    logic       illegal_op;
    logic       branch_ne;
  } ctrl_t;

  function automatic state_e dispatch(input logic [5:0] opcode);
    case (opcode)
      OpRType:                        return StRExec;
      OpLw, OpSw:                     return StMemAdr;
      OpBeq, OpBne:                   return StBranch;
      OpJ:                            return StJump;
      OpAddi, OpAndi, OpOri, OpSlti:  return StIExec;
      default:                        return StIllegal;
    endcase
  endfunction

  function automatic ctrl_t ctrl_decode(input state_e st, input logic [5:0] opcode);
    ctrl_t c;
    c             = '0;
    c.alu_op      = AluOpAdd;
    c.sign_extend = (st != StIdle);
    case (st)
      StFetch: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.pc_write  = 1'b1;
        c.ir_write  = 1'b1;
      end
      StDecode: c.alu_src_b = 2'b11;
      StMemAdr: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      StMemRd: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      StMemWb: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      StMemWr: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      StRExec: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = AluOpFunc;
      end
      StRWb: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      StBranch: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = AluOpSub;
        c.pc_source = 2'b01;
        c.pc_write  = 1'b1;
        c.branch_ne = (opcode == OpBne);
      end
      StJump: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      StIExec: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        case (opcode)
          OpAndi: begin
            c.alu_op      = AluOpAnd;
            c.sign_extend = 1'b0;
          end
          OpOri: begin
            c.alu_op      = AluOpOr;
            c.sign_extend = 1'b0;
          end
          OpSlti:  c.alu_op = AluOpSlt;
          default: c.alu_op = AluOpAdd;
        endcase
      end
      StIWb:     c.reg_write  = 1'b1;
      StIllegal: c.illegal_op = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_wait_counter.sv
// Memory wait counter: counts stalled cycles in a memory state and flags the timeout cycle.
module mc_wait_counter #(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned CNT_W      = 8
) (
  input  logic CLK,
  input  logic Reset_L,
  input  logic active,
  input  logic ready,
  input  logic state_change,
  output logic timeout
);

  logic [CNT_W-1:0] cnt_q;
  logic             inc;

  assign inc     = active & ~ready;
  // A ready in the limit cycle masks the timeout.
  assign timeout = inc & (cnt_q == CNT_W'(WAIT_LIMIT - 1));

  always_ff @(negedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      cnt_q <= '0;
    end else if (state_change || timeout) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Moore controller for the multi-cycle MIPS datapath; state and outputs update on negedge CLK.
module multi_cycle_control
  import multi_cycle_control_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       CLK,
  input  logic       Reset_L,
  input  logic [5:0] Opcode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemToReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] ALUOp,
  output logic       SignExtend,
  output logic       IllegalOp,
  output logic       MemTimeout
);

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  logic   waiting, timeout, pc_gate;

  assign waiting = state_q inside {StFetch, StMemRd, StMemWr};

  mc_wait_counter #(
    .WAIT_LIMIT(WAIT_LIMIT),
    .CNT_W     (CNT_W)
  ) u_wait_counter (
    .CLK         (CLK),
    .Reset_L     (Reset_L),
    .active      (waiting),
    .ready       (MemReady),
    .state_change(state_d != state_q),
    .timeout     (timeout)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   state_d = StFetch;
      StFetch:  state_d = MemReady ? StDecode : StFetch;
      StDecode: state_d = dispatch(Opcode);
      StMemAdr: state_d = (Opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd: begin
        if (MemReady)     state_d = StMemWb;
        else if (timeout) state_d = StFetch;
      end
      StMemWr:  if (MemReady || timeout) state_d = StFetch;
      StRExec:  state_d = StRWb;
      StIExec:  state_d = StIWb;
      StMemWb, StRWb, StBranch, StJump, StIWb, StIllegal: state_d = StFetch;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are registered alongside the state so they follow it without decode glitches.
  always_ff @(negedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q <= StIdle;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_decode(state_d, Opcode);
    end
  end

  always_comb begin
    pc_gate = 1'b1;
    if (state_q == StFetch)       pc_gate = MemReady;
    else if (state_q == StBranch) pc_gate = ctrl_q.branch_ne ? ~Zero : Zero;
  end

  assign PCWrite    = ctrl_q.pc_write & pc_gate;
  assign IRWrite    = ctrl_q.ir_write & MemReady;
  assign IorD       = ctrl_q.iord;
  assign MemRead    = ctrl_q.mem_read;
  assign MemWrite   = ctrl_q.mem_write;
  assign MemToReg   = ctrl_q.mem_to_reg;
  assign RegDst     = ctrl_q.reg_dst;
  assign RegWrite   = ctrl_q.reg_write;
  assign ALUSrcA    = ctrl_q.alu_src_a;
  assign ALUSrcB    = ctrl_q.alu_src_b;
  assign PCSource   = ctrl_q.pc_source;
  assign ALUOp      = ctrl_q.alu_op;
  assign SignExtend = ctrl_q.sign_extend;
  assign IllegalOp  = ctrl_q.illegal_op;
  assign MemTimeout = timeout;

endmodule
